// File: rtl/writeback_unit.sv
// Register-file write-port arbiter: ALU results take priority, load results queue in a FIFO,
// and a pending-load scoreboard flags hazards for decode. Optional macro WB_BYPASS_EN.
module writeback_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_data,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_write_enable,
  output logic [4:0]       rf_write_reg,
  output logic [31:0]      rf_write_data,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [4:0]       r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pending;
  logic             r_we;
  logic [4:0]       r_wreg;
  logic [31:0]      r_wdata;

  logic             w_hs;
  logic             w_nonempty;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic [4:0]       w_head_rd;
  logic [31:0]      w_head_data;
  logic [31:0]      w_clr;
  logic [31:0]      w_set;
  logic [31:0]      w_pending_nxt;

  // Ready comes only from the registered count, so a pop while full cannot open the door early.
  assign mem_ready   = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_hs        = mem_valid && mem_ready;
  assign w_nonempty  = (r_count != '0);
  assign w_pop       = !alu_valid && w_nonempty;
  assign w_head_rd   = r_fifo_rd[r_head];
  assign w_head_data = r_fifo_data[r_head];

`ifdef WB_BYPASS_EN
  assign w_bypass = !alu_valid && !w_nonempty && w_hs;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_hs && !w_bypass;

  always_comb begin
    w_clr = '0;
    w_set = '0;
    if (w_pop) begin
      w_clr[w_head_rd] = 1'b1;
    end else if (w_bypass) begin
      w_clr[mem_rd] = 1'b1;
    end
    if (issue_valid) begin
      w_set[issue_rd] = 1'b1;
    end
    // Set after clear so a same-edge reissue wins; bit 0 is never pending.
    w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_tail]   <= mem_rd;
      r_fifo_data[r_tail] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_we      <= 1'b0;
      r_wreg    <= '0;
      r_wdata   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (alu_valid) begin
        r_we    <= (alu_rd != 5'd0);
        r_wreg  <= alu_rd;
        r_wdata <= alu_data;
      end else if (w_nonempty) begin
        r_we    <= (w_head_rd != 5'd0);
        r_wreg  <= w_head_rd;
        r_wdata <= w_head_data;
      end else if (w_bypass) begin
        r_we    <= (mem_rd != 5'd0);
        r_wreg  <= mem_rd;
        r_wdata <= mem_data;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign rs1_busy        = r_pending[rs1];
  assign rs2_busy        = r_pending[rs2];
  assign rf_write_enable = r_we;
  assign rf_write_reg    = r_wreg;
  assign rf_write_data   = r_wdata;
  assign fifo_count      = r_count;

endmodule
